// File: rtl/dfi_sram_responder_pkg.sv
// rtl/dfi_sram_responder_pkg.sv - DFI command encodings and burst constants
package dfi_sram_responder_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  typedef enum logic [3:0] {
    CMD_MRS = 4'b0000,
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_RD  = 4'b0101,
    CMD_ZQ  = 4'b0110,
    CMD_NOP = 4'b0111
  } dfi_cmd_e;

  localparam int          BL8_BEATS = 4;
  localparam logic [1:0]  BL8_LAST  = 2'(BL8_BEATS - 1);
  localparam int          T_CCD     = 4;
  localparam int          WQ_DEPTH  = 4;

endpackage

// File: rtl/dfi_sram_responder_if.sv
// rtl/dfi_sram_responder_if.sv - DFI port between controller and SRAM-backed responder
interface dfi_sram_responder_if #(
  parameter int ROW_BITS = 13
);
  logic                dfi_rst_ni;
  logic                dfi_cke_i;
  logic                dfi_cs_ni;
  logic                dfi_ras_ni;
  logic                dfi_cas_ni;
  logic                dfi_we_ni;
  logic                dfi_odt_i;
  logic [2:0]          dfi_bank_i;
  logic [ROW_BITS-1:0] dfi_addr_i;
  logic                dfi_wstb_i;
  logic                dfi_wren_i;
  logic [3:0]          dfi_mask_i;
  logic [31:0]         dfi_data_i;
  logic                dfi_rden_i;
  logic                dfi_rvld_o;
  logic                dfi_last_o;
  logic [31:0]         dfi_data_o;
  logic                dfi_align_i;
  logic                dfi_calib_o;
  logic [2:0]          dfi_shift_o;
  logic [3:0]          err_o;

  modport master (
    output dfi_rst_ni, dfi_cke_i, dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni, dfi_odt_i,
           dfi_bank_i, dfi_addr_i, dfi_wstb_i, dfi_wren_i, dfi_mask_i, dfi_data_i, dfi_rden_i,
           dfi_align_i,
    input  dfi_rvld_o, dfi_last_o, dfi_data_o, dfi_calib_o, dfi_shift_o, err_o
  );

  modport slave (
    input  dfi_rst_ni, dfi_cke_i, dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni, dfi_odt_i,
           dfi_bank_i, dfi_addr_i, dfi_wstb_i, dfi_wren_i, dfi_mask_i, dfi_data_i, dfi_rden_i,
           dfi_align_i,
    output dfi_rvld_o, dfi_last_o, dfi_data_o, dfi_calib_o, dfi_shift_o, err_o
  );
endinterface

// File: rtl/dfi_model_sram.sv
// rtl/dfi_model_sram.sv - 32-bit SRAM, byte-enabled sync write, 1-cycle sync read
module dfi_model_sram #(
  parameter int ABITS = 10
) (
  input  logic             clock,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [3:0]       wbe,
  input  logic [31:0]      wdata,
  input  logic             re,
  input  logic [ABITS-1:0] raddr,
  output logic [31:0]      rdata
);
  logic [31:0] mem [2**ABITS];

  // Read returns the pre-write contents on an address collision
  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/dfi_sram_responder.sv
// rtl/dfi_sram_responder.sv - DFI far-end responder backed by on-chip SRAM
module dfi_sram_responder
  import dfi_sram_responder_pkg::*;
#(
  parameter int         DDR_ROW_BITS = 13,
  parameter int         DDR_COL_BITS = 10,
  parameter int         SRAM_ABITS   = 10,
  parameter int         PHY_RD_DELAY = 3,
  parameter int         CALIB_DELAY  = 8,
  parameter logic [2:0] CALIB_SHIFT  = 3'b010
) (
  input  logic               clock,
  input  logic               arst_n,
  dfi_sram_responder_if.slave dfi
);
  localparam int BW = SRAM_ABITS - 2;
  localparam int KW = DDR_ROW_BITS + 3 + DDR_COL_BITS - 3;
  localparam int CW = $clog2(CALIB_DELAY + 1);

  typedef struct packed {
    logic                  vld;
    logic                  last;
    logic [SRAM_ABITS-1:0] addr;
  } rd_beat_t;

  dfi_cmd_e cmd;
  always_comb begin
    cmd = CMD_NOP;
    if (dfi.dfi_cke_i && !dfi.dfi_cs_ni)
      cmd = dfi_cmd_e'({1'b0, dfi.dfi_ras_ni, dfi.dfi_cas_ni, dfi.dfi_we_ni});
  end

  logic [7:0]              bank_open;
  logic [DDR_ROW_BITS-1:0] bank_row [8];
  logic [2:0]              bank;
  logic                    is_open;
  logic [KW-1:0]           cmd_key;
  logic [BW-1:0]           cmd_base;

  assign bank     = dfi.dfi_bank_i;
  assign is_open  = bank_open[bank];
  assign cmd_key  = {bank_row[bank], bank, dfi.dfi_addr_i[DDR_COL_BITS-1:3]};
  assign cmd_base = cmd_key[BW-1:0];

  always_ff @(posedge clock) begin
    if (cmd == CMD_ACT) bank_row[bank] <= dfi.dfi_addr_i;
  end

  // SDRAM reset wins over any command decoded in the same cycle
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      bank_open <= '0;
    end else if (!dfi.dfi_rst_ni) begin
      bank_open <= '0;
    end else begin
      case (cmd)
        CMD_ACT: bank_open[bank] <= 1'b1;
        CMD_PRE: begin
          if (dfi.dfi_addr_i[10]) bank_open <= '0;
          else                    bank_open[bank] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  logic [BW-1:0] wq [WQ_DEPTH];
  logic [1:0]    wq_wp, wq_rp, wbeat;
  logic [2:0]    wq_cnt;
  logic          wq_full, wq_empty, wr_push, wr_pop, wbeat_ok;

  assign wq_full  = (wq_cnt == 3'(WQ_DEPTH));
  assign wq_empty = (wq_cnt == 3'd0);
  assign wr_push  = (cmd == CMD_WR) && is_open && !wq_full;
  assign wbeat_ok = dfi.dfi_wren_i && !wq_empty;
  assign wr_pop   = wbeat_ok && (wbeat == BL8_LAST);

  always_ff @(posedge clock) begin
    if (wr_push) wq[wq_wp] <= cmd_base;
  end

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      wq_wp  <= '0;
      wq_rp  <= '0;
      wq_cnt <= '0;
      wbeat  <= '0;
    end else begin
      if (wr_push)  wq_wp <= wq_wp + 2'd1;
      if (wr_pop)   wq_rp <= wq_rp + 2'd1;
      if (wbeat_ok) wbeat <= wbeat + 2'd1;
      case ({wr_push, wr_pop})
        2'b10:   wq_cnt <= wq_cnt + 3'd1;
        2'b01:   wq_cnt <= wq_cnt - 3'd1;
        default: ;
      endcase
    end
  end

  logic [2:0]    rd_gap;
  logic          rd_ok, gap_ok;
  logic          gen_act;
  logic [1:0]    gen_beat;
  logic [BW-1:0] gen_base;
  rd_beat_t      pipe [PHY_RD_DELAY];
  logic          rvld_q, last_q;
  logic [31:0]   sram_q;

  assign gap_ok = (rd_gap >= 3'(T_CCD));
  assign rd_ok  = (cmd == CMD_RD) && is_open && gap_ok;

  // The beat generator counts as the first delay stage; the SRAM read is the last
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      rd_gap   <= 3'(T_CCD);
      gen_act  <= 1'b0;
      gen_beat <= '0;
      gen_base <= '0;
      rvld_q   <= 1'b0;
      last_q   <= 1'b0;
      for (int i = 0; i < PHY_RD_DELAY; i++) pipe[i] <= '0;
    end else begin
      if (rd_ok)        rd_gap <= 3'd1;
      else if (!gap_ok) rd_gap <= rd_gap + 3'd1;
      if (rd_ok) begin
        gen_act  <= 1'b1;
        gen_beat <= '0;
        gen_base <= cmd_base;
      end else if (gen_act) begin
        gen_beat <= gen_beat + 2'd1;
        if (gen_beat == BL8_LAST) gen_act <= 1'b0;
      end
      pipe[0] <= '{vld: gen_act, last: gen_act && (gen_beat == BL8_LAST), addr: {gen_base, gen_beat}};
      for (int i = 1; i < PHY_RD_DELAY; i++) pipe[i] <= pipe[i-1];
      rvld_q <= pipe[PHY_RD_DELAY-1].vld;
      last_q <= pipe[PHY_RD_DELAY-1].last;
    end
  end

  dfi_model_sram #(.ABITS(SRAM_ABITS)) u_sram (
    .clock (clock),
    .we    (wbeat_ok),
    .waddr ({wq[wq_rp], wbeat}),
    .wbe   (~dfi.dfi_mask_i),
    .wdata (dfi.dfi_data_i),
    .re    (pipe[PHY_RD_DELAY-1].vld),
    .raddr (pipe[PHY_RD_DELAY-1].addr),
    .rdata (sram_q)
  );

  assign dfi.dfi_rvld_o = rvld_q;
  assign dfi.dfi_last_o = last_q;
  assign dfi.dfi_data_o = rvld_q ? sram_q : 32'd0;

  logic [CW-1:0] cal_cnt;
  logic          calib_q;
  logic [2:0]    shift_q;

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      cal_cnt <= '0;
      calib_q <= 1'b0;
      shift_q <= '0;
    end else if (!dfi.dfi_align_i) begin
      cal_cnt <= '0;
      calib_q <= 1'b0;
    end else if (!calib_q) begin
      if (cal_cnt == CW'(CALIB_DELAY)) begin
        calib_q <= 1'b1;
        shift_q <= CALIB_SHIFT;
      end else begin
        cal_cnt <= cal_cnt + 1'b1;
      end
    end
  end

  assign dfi.dfi_calib_o = calib_q;
  assign dfi.dfi_shift_o = shift_q;

  logic [3:0] err_q, err_set;
  assign err_set = {
    (cmd == CMD_RD) && is_open && !gap_ok,
    ((cmd == CMD_WR) && is_open && wq_full) || (dfi.dfi_wren_i && wq_empty),
    (cmd == CMD_ACT) && is_open,
    ((cmd == CMD_RD) || (cmd == CMD_WR)) && !is_open
  };

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) err_q <= '0;
    else         err_q <= err_q | err_set;
  end

  assign dfi.err_o = err_q;

  wire unused_ok = &{1'b0, dfi.dfi_odt_i, dfi.dfi_wstb_i, dfi.dfi_rden_i, cmd_key[KW-1:BW]};
endmodule

// File: tb/tb_dfi_sram_responder.sv
// tb/tb_dfi_sram_responder.sv - directed self-checking bench for dfi_sram_responder
module tb_dfi_sram_responder;
  import dfi_sram_responder_pkg::*;

  logic clock = 1'b0;
  logic arst_n = 1'b0;
  always #5 clock = ~clock;

  dfi_sram_responder_if #(.ROW_BITS(13)) dfi ();

  dfi_sram_responder #(
    .DDR_ROW_BITS(13), .DDR_COL_BITS(10), .SRAM_ABITS(10),
    .PHY_RD_DELAY(3), .CALIB_DELAY(8), .CALIB_SHIFT(3'b010)
  ) dut (
    .clock  (clock),
    .arst_n (arst_n),
    .dfi    (dfi)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0]  s_cmd  [32];
  logic [2:0]  s_bank [32];
  logic [12:0] s_addr [32];
  logic        rv [32];
  logic        ls [32];
  logic [31:0] dt [32];

  logic [3:0][31:0] burst0, burst1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cmd(input logic [3:0] c, input logic [2:0] b, input logic [12:0] a);
    {dfi.dfi_cs_ni, dfi.dfi_ras_ni, dfi.dfi_cas_ni, dfi.dfi_we_ni} = c;
    dfi.dfi_bank_i = b;
    dfi.dfi_addr_i = a;
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 32; i++) begin
      s_cmd[i] = CMD_NOP;
      s_bank[i] = '0;
      s_addr[i] = '0;
    end
  endtask

  // Drive s_*[k] for edge k, capture outputs just after edge k
  task automatic run_seq(input int n);
    for (int k = 0; k < n; k++) begin
      set_cmd(s_cmd[k], s_bank[k], s_addr[k]);
      tick();
      rv[k] = dfi.dfi_rvld_o;
      ls[k] = dfi.dfi_last_o;
      dt[k] = dfi.dfi_data_o;
    end
    set_cmd(CMD_NOP, 3'd0, 13'd0);
  endtask

  task automatic write_burst(input logic [2:0] b, input logic [12:0] col,
                             input logic [3:0][31:0] d, input logic [3:0][3:0] m);
    set_cmd(CMD_WR, b, col);
    tick();
    set_cmd(CMD_NOP, 3'd0, 13'd0);
    for (int i = 0; i < 4; i++) begin
      dfi.dfi_wren_i = 1'b1;
      dfi.dfi_data_i = d[i];
      dfi.dfi_mask_i = m[i];
      tick();
    end
    dfi.dfi_wren_i = 1'b0;
    dfi.dfi_mask_i = 4'h0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    repeat (3) tick();
    tests_run++; if (dfi.dfi_rvld_o !== 1'b0) begin tests_failed++; $display("FAIL reset_rvld got %b want 0", dfi.dfi_rvld_o); end
    tests_run++; if (dfi.dfi_last_o !== 1'b0) begin tests_failed++; $display("FAIL reset_last got %b want 0", dfi.dfi_last_o); end
    tests_run++; if (dfi.dfi_data_o !== 32'd0) begin tests_failed++; $display("FAIL reset_data got %h want 0", dfi.dfi_data_o); end
    tests_run++; if (dfi.dfi_calib_o !== 1'b0) begin tests_failed++; $display("FAIL reset_calib got %b want 0", dfi.dfi_calib_o); end
    tests_run++; if (dfi.dfi_shift_o !== 3'd0) begin tests_failed++; $display("FAIL reset_shift got %b want 000", dfi.dfi_shift_o); end
    tests_run++; if (dfi.err_o !== 4'd0) begin tests_failed++; $display("FAIL reset_err got %b want 0000", dfi.err_o); end
    arst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    logic [3:0][3:0] m;
    logic exp_v;
    m = '0;
    burst0[0] = 32'h11111111; burst0[1] = 32'h22222222;
    burst0[2] = 32'h33333333; burst0[3] = 32'h44444444;
    clear_sched();
    s_cmd[0] = CMD_ACT; s_bank[0] = 3'd0; s_addr[0] = 13'd5;
    run_seq(2);
    write_burst(3'd0, 13'd0, burst0, m);
    tick();
    clear_sched();
    s_cmd[0] = CMD_RD; s_bank[0] = 3'd0; s_addr[0] = 13'd0;
    run_seq(10);
    for (int k = 0; k < 10; k++) begin
      exp_v = (k >= 4) && (k <= 7);
      tests_run++; if (rv[k] !== exp_v) begin tests_failed++; $display("FAIL wr_rd_rvld[%0d] got %b want %b", k, rv[k], exp_v); end
      tests_run++; if (ls[k] !== (k == 7)) begin tests_failed++; $display("FAIL wr_rd_last[%0d] got %b want %b", k, ls[k], k == 7); end
      if (exp_v) begin
        tests_run++; if (dt[k] !== burst0[k-4]) begin tests_failed++; $display("FAIL wr_rd_data[%0d] got %h want %h", k, dt[k], burst0[k-4]); end
      end
    end
  endtask

  task automatic test_byte_mask();
    logic [3:0][31:0] d;
    logic [3:0][3:0] m;
    m = '0;
    d[0] = 32'h55555555; d[1] = 32'h66666666; d[2] = 32'hAAAAAAAA; d[3] = 32'h88888888;
    write_burst(3'd0, 13'd8, d, m);
    burst1 = d;
    d[2] = 32'hFFFFFFFF;
    m[0] = 4'hF; m[1] = 4'hF; m[2] = 4'b0101; m[3] = 4'hF;
    write_burst(3'd0, 13'd8, d, m);
    burst1[2] = 32'hFFAAFFAA;
    tick();
    clear_sched();
    s_cmd[0] = CMD_RD; s_bank[0] = 3'd0; s_addr[0] = 13'd8;
    run_seq(9);
    for (int k = 4; k < 8; k++) begin
      tests_run++; if (rv[k] !== 1'b1) begin tests_failed++; $display("FAIL mask_rvld[%0d] got %b want 1", k, rv[k]); end
      tests_run++; if (dt[k] !== burst1[k-4]) begin tests_failed++; $display("FAIL mask_data[%0d] got %h want %h", k, dt[k], burst1[k-4]); end
    end
  endtask

  task automatic test_closed_bank();
    clear_sched();
    s_cmd[0] = CMD_RD; s_bank[0] = 3'd3; s_addr[0] = 13'd0;
    run_seq(10);
    for (int k = 0; k < 10; k++) begin
      tests_run++; if (rv[k] !== 1'b0) begin tests_failed++; $display("FAIL closed_rvld[%0d] got %b want 0", k, rv[k]); end
    end
    tests_run++; if (dfi.err_o !== 4'b0001) begin tests_failed++; $display("FAIL closed_err got %b want 0001", dfi.err_o); end
    clear_sched();
    s_cmd[0] = CMD_ACT; s_bank[0] = 3'd3; s_addr[0] = 13'd1;
    s_cmd[1] = CMD_ACT; s_bank[1] = 3'd3; s_addr[1] = 13'd2;
    run_seq(3);
    tests_run++; if (dfi.err_o !== 4'b0011) begin tests_failed++; $display("FAIL double_act_err got %b want 0011", dfi.err_o); end
  endtask

  task automatic test_back_to_back();
    logic exp_v, exp_l;
    logic [31:0] exp_d;
    clear_sched();
    s_cmd[0] = CMD_RD; s_bank[0] = 3'd0; s_addr[0] = 13'd0;
    s_cmd[4] = CMD_RD; s_bank[4] = 3'd0; s_addr[4] = 13'd8;
    s_cmd[6] = CMD_RD; s_bank[6] = 3'd0; s_addr[6] = 13'd0;
    run_seq(16);
    for (int k = 0; k < 16; k++) begin
      exp_v = (k >= 4) && (k <= 11);
      exp_l = (k == 7) || (k == 11);
      tests_run++; if (rv[k] !== exp_v) begin tests_failed++; $display("FAIL b2b_rvld[%0d] got %b want %b", k, rv[k], exp_v); end
      tests_run++; if (ls[k] !== exp_l) begin tests_failed++; $display("FAIL b2b_last[%0d] got %b want %b", k, ls[k], exp_l); end
      if (exp_v) begin
        exp_d = (k < 8) ? burst0[k-4] : burst1[k-8];
        tests_run++; if (dt[k] !== exp_d) begin tests_failed++; $display("FAIL b2b_data[%0d] got %h want %h", k, dt[k], exp_d); end
      end
    end
    tests_run++; if (dfi.err_o !== 4'b1011) begin tests_failed++; $display("FAIL tccd_err got %b want 1011", dfi.err_o); end
  endtask

  task automatic test_calib();
    dfi.dfi_align_i = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      tick();
      tests_run++; if (dfi.dfi_calib_o !== (k == 8)) begin tests_failed++; $display("FAIL calib[%0d] got %b want %b", k, dfi.dfi_calib_o, k == 8); end
    end
    tests_run++; if (dfi.dfi_shift_o !== 3'b010) begin tests_failed++; $display("FAIL calib_shift got %b want 010", dfi.dfi_shift_o); end
    dfi.dfi_align_i = 1'b0;
    tick();
    tests_run++; if (dfi.dfi_calib_o !== 1'b0) begin tests_failed++; $display("FAIL calib_drop got %b want 0", dfi.dfi_calib_o); end
  endtask

  task automatic test_reset_mid_burst();
    clear_sched();
    s_cmd[0] = CMD_RD; s_bank[0] = 3'd0; s_addr[0] = 13'd0;
    run_seq(6);
    tests_run++; if (rv[5] !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_rvld got %b want 1", rv[5]); end
    arst_n = 1'b0;
    #1;
    tests_run++; if (dfi.dfi_rvld_o !== 1'b0) begin tests_failed++; $display("FAIL mid_rvld got %b want 0", dfi.dfi_rvld_o); end
    tests_run++; if (dfi.dfi_data_o !== 32'd0) begin tests_failed++; $display("FAIL mid_data got %h want 0", dfi.dfi_data_o); end
    tests_run++; if (dfi.err_o !== 4'd0) begin tests_failed++; $display("FAIL mid_err got %b want 0000", dfi.err_o); end
    tick();
    arst_n = 1'b1;
    tick();
    clear_sched();
    s_cmd[0] = CMD_RD; s_bank[0] = 3'd0; s_addr[0] = 13'd0;
    run_seq(10);
    for (int k = 0; k < 10; k++) begin
      tests_run++; if (rv[k] !== 1'b0) begin tests_failed++; $display("FAIL post_rst_rvld[%0d] got %b want 0", k, rv[k]); end
    end
    tests_run++; if (dfi.err_o !== 4'b0001) begin tests_failed++; $display("FAIL post_rst_err got %b want 0001", dfi.err_o); end
  endtask

  initial begin
    dfi.dfi_rst_ni  = 1'b1;
    dfi.dfi_cke_i   = 1'b1;
    dfi.dfi_odt_i   = 1'b0;
    dfi.dfi_wstb_i  = 1'b0;
    dfi.dfi_wren_i  = 1'b0;
    dfi.dfi_mask_i  = 4'h0;
    dfi.dfi_data_i  = 32'd0;
    dfi.dfi_rden_i  = 1'b0;
    dfi.dfi_align_i = 1'b0;
    set_cmd(CMD_NOP, 3'd0, 13'd0);
    clear_sched();
    test_reset();
    test_write_read();
    test_byte_mask();
    test_closed_bank();
    test_back_to_back();
    test_calib();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
